// File: rtl/pkt_xlate_pkg.sv
// Shared types and helpers for the packet width upsizer.
// Optional packet statistics are enabled by PACKET_WIDTH_UPSIZER_STATS_EN.
package pkt_xlate_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Bit positions inside oerr_sticky
  typedef enum int {
    ERR_MISSING_EOP = 0,
    ERR_ORPHAN      = 1,
    ERR_LEN_OVF     = 2
  } err_idx_e;

  localparam int ERR_W = 3;

  // Residual byte-count width; kept at least one bit so byte-wide words still elaborate
  function automatic int resid_w(input int in_w);
    return (in_w / 8 > 1) ? $clog2(in_w / 8) : 1;
  endfunction

endpackage

// File: rtl/packet_width_upsizer_if.sv
// Ingress word stream and egress beat stream of the packet width upsizer.
// master = upsizer side, slave = source/sink side.
interface packet_width_upsizer_if #(
  parameter int IN_W  = 32,
  parameter int RATIO = 2,
  parameter int LEN_W = 14
);
  localparam int OUT_W   = IN_W * RATIO;
  localparam int RESID_W = pkt_xlate_pkg::resid_w(IN_W);

  logic               ivalid;
  logic               iready;
  logic               isop;
  logic               ieop;
  logic [RESID_W-1:0] iresidual;
  logic [IN_W-1:0]    idata;
  logic               ibad;

  logic               ovalid;
  logic               oready;
  logic               osop;
  logic               oeop;
  logic [OUT_W-1:0]   odata;
  logic [LEN_W-1:0]   oplen;
  logic               obad;

  modport master (
    input  ivalid, isop, ieop, iresidual, idata, ibad, oready,
    output iready, ovalid, osop, oeop, odata, oplen, obad
  );

  modport slave (
    output ivalid, isop, ieop, iresidual, idata, ibad, oready,
    input  iready, ovalid, osop, oeop, odata, oplen, obad
  );

endinterface

// File: rtl/pkt_beat_reg.sv
// One-entry valid/ready output register; accepts a new beat whenever it is
// empty or its current beat is being taken in the same cycle.
module pkt_beat_reg #(
  parameter type beat_t = logic
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  in_valid,
  output logic  in_ready,
  input  beat_t in_beat,
  output logic  out_valid,
  input  logic  out_ready,
  output beat_t out_beat
);

  logic  valid_reg;
  beat_t beat_reg;

  assign in_ready  = ~valid_reg | out_ready;
  assign out_valid = valid_reg;
  assign out_beat  = beat_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      beat_reg  <= '0;
    end else if (in_ready) begin
      valid_reg <= in_valid;
      if (in_valid) begin
        beat_reg <= in_beat;
      end
    end
  end

endmodule

// File: rtl/packet_width_upsizer.sv
// N:1 packet width upsizer: packs RATIO ingress words into one egress beat,
// tracks packet length and protocol errors. Stats gated by PACKET_WIDTH_UPSIZER_STATS_EN.
module packet_width_upsizer
  import pkt_xlate_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int RATIO = 2,
  parameter int LEN_W = 14
) (
  input  logic                    iclk,
  input  logic                    irst_n,
  packet_width_upsizer_if.master  bus,
  output logic [ERR_W-1:0]        oerr_sticky,
  output logic [31:0]             opkt_cnt
);

  localparam int OUT_W   = IN_W * RATIO;
  localparam int LANE_W  = $clog2(RATIO);
  localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(RATIO - 1);
  localparam logic [LEN_W:0]    WORD_BYTES = (LEN_W + 1)'(IN_W / 8);
  localparam logic [LEN_W-1:0]  LEN_MAX    = '1;

  typedef struct packed {
    logic             sop;
    logic             eop;
    logic             bad;
    logic [LEN_W-1:0] len;
    logic [OUT_W-1:0] data;
  } beat_t;

  state_t            state_reg, state_next;
  logic [LANE_W-1:0] lane_reg, lane_next;
  logic [OUT_W-1:0]  acc_reg, acc_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic              ovf_reg, ovf_next;
  logic              sop_reg, sop_next;
  beat_t             hold_reg, hold_next;
  logic [ERR_W-1:0]  err_reg, err_next;
  logic              en_reg;

  logic              accept;
  logic              pkt_word;
  logic              push_valid;
  logic              push_ready;
  beat_t             push_beat;
  logic              out_valid;
  beat_t             out_beat;

  logic [OUT_W-1:0]  merged;
  logic [OUT_W-1:0]  fresh;
  logic [LEN_W:0]    word_len;
  logic [LEN_W:0]    len_sum;
  logic [LEN_W-1:0]  len_word;
  logic              ovf_word;

  // merged: accumulator with the incoming word dropped into the current lane
  // fresh:  incoming word alone in lane 0, as the start of a new packet
  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_lane
      localparam int HI = OUT_W - 1 - gi * IN_W;
      assign merged[HI -: IN_W] = (lane_reg == LANE_W'(gi)) ? bus.idata : acc_reg[HI -: IN_W];
      if (gi == 0) begin : g_first
        assign fresh[HI -: IN_W] = bus.idata;
      end else begin : g_rest
        assign fresh[HI -: IN_W] = '0;
      end
    end
  endgenerate

  assign word_len = (bus.ieop && (bus.iresidual != '0)) ? (LEN_W + 1)'(bus.iresidual) : WORD_BYTES;
  assign len_sum  = (bus.isop ? '0 : {1'b0, len_reg}) + word_len;
  assign len_word = len_sum[LEN_W] ? LEN_MAX : len_sum[LEN_W-1:0];
  assign ovf_word = len_sum[LEN_W] | (~bus.isop & ovf_reg);

  // en_reg keeps iready low while reset is asserted and for the first edge after
  assign bus.iready = en_reg & (state_reg != HOLD) & push_ready;
  assign accept     = bus.ivalid & bus.iready;
  assign pkt_word   = accept & (bus.isop | (state_reg == ACCUM));

  always_comb begin
    state_next = state_reg;
    lane_next  = lane_reg;
    acc_next   = acc_reg;
    len_next   = len_reg;
    ovf_next   = ovf_reg;
    sop_next   = sop_reg;
    hold_next  = hold_reg;
    err_next   = err_reg;
    push_valid = 1'b0;
    push_beat  = '0;

    if (pkt_word) begin
      len_next = len_word;
      ovf_next = ovf_word;
      if (len_sum[LEN_W]) begin
        err_next[ERR_LEN_OVF] = 1'b1;
      end
    end

    case (state_reg)
      IDLE: begin
        if (accept && !bus.isop) begin
          err_next[ERR_ORPHAN] = 1'b1;
        end else if (accept && bus.ieop) begin
          push_valid     = 1'b1;
          push_beat.sop  = 1'b1;
          push_beat.eop  = 1'b1;
          push_beat.bad  = bus.ibad | ovf_word;
          push_beat.len  = len_word;
          push_beat.data = fresh;
          acc_next       = '0;
          lane_next      = '0;
          sop_next       = 1'b0;
        end else if (accept) begin
          acc_next   = fresh;
          lane_next  = LANE_W'(1);
          sop_next   = 1'b1;
          state_next = ACCUM;
        end
      end

      ACCUM: begin
        if (accept && bus.isop) begin
          // Missing eop: close the old packet as bad, then restart on this word
          err_next[ERR_MISSING_EOP] = 1'b1;
          push_valid     = 1'b1;
          push_beat.sop  = sop_reg;
          push_beat.eop  = 1'b1;
          push_beat.bad  = 1'b1;
          push_beat.len  = len_reg;
          push_beat.data = acc_reg;
          if (bus.ieop) begin
            hold_next.sop  = 1'b1;
            hold_next.eop  = 1'b1;
            hold_next.bad  = bus.ibad | ovf_word;
            hold_next.len  = len_word;
            hold_next.data = fresh;
            acc_next       = '0;
            lane_next      = '0;
            sop_next       = 1'b0;
            state_next     = HOLD;
          end else begin
            acc_next  = fresh;
            lane_next = LANE_W'(1);
            sop_next  = 1'b1;
          end
        end else if (accept && (bus.ieop || (lane_reg == LAST_LANE))) begin
          push_valid     = 1'b1;
          push_beat.sop  = sop_reg;
          push_beat.eop  = bus.ieop;
          push_beat.bad  = bus.ieop & (bus.ibad | ovf_word);
          push_beat.len  = len_word;
          push_beat.data = merged;
          acc_next       = '0;
          lane_next      = '0;
          sop_next       = 1'b0;
          if (bus.ieop) begin
            state_next = IDLE;
          end
        end else if (accept) begin
          acc_next  = merged;
          lane_next = lane_reg + LANE_W'(1);
        end
      end

      HOLD: begin
        push_valid = 1'b1;
        push_beat  = hold_reg;
        if (push_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_reg <= IDLE;
      lane_reg  <= '0;
      acc_reg   <= '0;
      len_reg   <= '0;
      ovf_reg   <= 1'b0;
      sop_reg   <= 1'b0;
      hold_reg  <= '0;
      err_reg   <= '0;
      en_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      lane_reg  <= lane_next;
      acc_reg   <= acc_next;
      len_reg   <= len_next;
      ovf_reg   <= ovf_next;
      sop_reg   <= sop_next;
      hold_reg  <= hold_next;
      err_reg   <= err_next;
      en_reg    <= 1'b1;
    end
  end

  pkt_beat_reg #(
    .beat_t (beat_t)
  ) u_beat_reg (
    .clk       (iclk),
    .rst_n     (irst_n),
    .in_valid  (push_valid),
    .in_ready  (push_ready),
    .in_beat   (push_beat),
    .out_valid (out_valid),
    .out_ready (bus.oready),
    .out_beat  (out_beat)
  );

  assign bus.ovalid  = out_valid;
  assign bus.osop    = out_beat.sop;
  assign bus.oeop    = out_beat.eop;
  assign bus.obad    = out_beat.bad;
  assign bus.oplen   = out_beat.len;
  assign bus.odata   = out_beat.data;
  assign oerr_sticky = err_reg;

`ifdef PACKET_WIDTH_UPSIZER_STATS_EN
  logic [31:0] pkt_cnt_reg;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      pkt_cnt_reg <= '0;
    end else if (out_valid && bus.oready && out_beat.eop) begin
      pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
    end
  end

  assign opkt_cnt = pkt_cnt_reg;
`else
  assign opkt_cnt = '0;
`endif

endmodule

// File: tb/tb_packet_width_upsizer.sv
// Directed bench for packet_width_upsizer (IN_W=32, RATIO=2, LEN_W=14).
// Expects opkt_cnt to count only when PACKET_WIDTH_UPSIZER_STATS_EN is defined.
module tb_packet_width_upsizer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [2:0]  err;
  logic [31:0] pkt_cnt;

  int checks = 0;
  int failures = 0;
  bit quiet = 1'b0;

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic        bad;
    logic [13:0] len;
  } beat_s;

  beat_s q[$];

  always #5 clk = ~clk;

  packet_width_upsizer_if #(.IN_W(32), .RATIO(2), .LEN_W(14)) bus ();

  packet_width_upsizer #(.IN_W(32), .RATIO(2), .LEN_W(14)) dut (
    .iclk        (clk),
    .irst_n      (rst_n),
    .bus         (bus),
    .oerr_sticky (err),
    .opkt_cnt    (pkt_cnt)
  );

  // Inputs change at posedge+1, so a beat seen valid&ready here is taken at the next edge
  always @(negedge clk) begin
    if (rst_n && bus.ovalid && bus.oready) begin
      beat_s b;
      b.data = bus.odata;
      b.sop  = bus.osop;
      b.eop  = bus.oeop;
      b.bad  = bus.obad;
      b.len  = bus.oplen;
      q.push_back(b);
      if (!quiet)
        $display("beat data=%h sop=%0b eop=%0b bad=%0b len=%0d", b.data, b.sop, b.eop, b.bad, b.len);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic sop, input logic eop, input logic [1:0] resid,
                      input logic [31:0] d, input logic bad);
    int n = 0;
    logic ok = 1'b0;
    bus.ivalid    = 1'b1;
    bus.isop      = sop;
    bus.ieop      = eop;
    bus.iresidual = resid;
    bus.idata     = d;
    bus.ibad      = bad;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = bus.iready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.ivalid = 1'b0;
    bus.isop   = 1'b0;
    bus.ieop   = 1'b0;
    if (!ok) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_beats(input int n, input int budget);
    int c = 0;
    while (q.size() < n && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (q.size() < n) check("beat_timeout", 64'(q.size()), 64'(n));
  endtask

  task automatic expect_beat(input string tag, input logic [63:0] data, input logic sop,
                             input logic eop, input logic bad, input logic [13:0] len);
    beat_s b;
    if (q.size() == 0) begin
      check({tag, "_present"}, 64'd0, 64'd1);
    end else begin
      b = q.pop_front();
      check({tag, "_data"}, b.data, data);
      check({tag, "_sop_eop_bad"}, {61'd0, b.sop, b.eop, b.bad}, {61'd0, sop, eop, bad});
      check({tag, "_len"}, 64'(b.len), 64'(len));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_cnt;
    int eop_beats;
    beat_s last;

    bus.ivalid = 1'b0; bus.isop = 1'b0; bus.ieop = 1'b0; bus.iresidual = '0;
    bus.idata = '0; bus.ibad = 1'b0; bus.oready = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state, with the sink ready so iready would otherwise be high
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_iready", 64'(bus.iready), 64'd0);
    check("rst_ovalid", 64'(bus.ovalid), 64'd0);
    check("rst_odata", bus.odata, 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Three-word packet with 2-byte residual
    send(1, 0, 2'd0, 32'h0000000A, 0);
    send(0, 0, 2'd0, 32'h0000000B, 0);
    send(0, 1, 2'd2, 32'h0000000C, 0);
    wait_beats(2, 50);
    expect_beat("t1_b0", 64'h0000000A_0000000B, 1, 0, 0, 14'd8);
    expect_beat("t1_b1", 64'h0000000C_00000000, 0, 1, 0, 14'd10);

    // Single-word packet
    send(1, 1, 2'd0, 32'h00000011, 0);
    wait_beats(1, 50);
    expect_beat("t2_single", 64'h00000011_00000000, 1, 1, 0, 14'd4);

    // Six-word packet with the sink stalled after the first beat
    bus.oready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(i == 0, i == 5, 2'd0, 32'h100 + 32'(i), 0);
      end
      begin
        int n = 0;
        while (!bus.ovalid && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        @(negedge clk);
        check("bp_ovalid", 64'(bus.ovalid), 64'd1);
        check("bp_iready_low", 64'(bus.iready), 64'd0);
        repeat (5) @(posedge clk);
        #1 bus.oready = 1'b1;
      end
    join
    wait_beats(3, 50);
    check("bp_count", 64'(q.size()), 64'd3);
    expect_beat("bp_b0", 64'h00000100_00000101, 1, 0, 0, 14'd8);
    expect_beat("bp_b1", 64'h00000102_00000103, 0, 0, 0, 14'd16);
    expect_beat("bp_b2", 64'h00000104_00000105, 0, 1, 0, 14'd24);
    check("bp_err", 64'(err), 64'd0);

    // Bad-marked packet with a 1-byte residual
    send(1, 0, 2'd0, 32'h00000005, 0);
    send(0, 1, 2'd1, 32'h00000006, 1);
    wait_beats(1, 50);
    expect_beat("bad_pkt", 64'h00000005_00000006, 1, 1, 1, 14'd5);

    // Missing eop: new sop+eop word aborts the open packet
    send(1, 0, 2'd0, 32'h00000001, 0);
    send(1, 1, 2'd0, 32'h00000002, 0);
    wait_beats(2, 50);
    expect_beat("abort_old", 64'h00000001_00000000, 1, 1, 1, 14'd4);
    expect_beat("abort_new", 64'h00000002_00000000, 1, 1, 0, 14'd4);
    check("abort_err", 64'(err), 64'd1);

    // Orphan word in IDLE is dropped
    send(0, 1, 2'd0, 32'h000000EE, 0);
    idle(5);
    check("orphan_no_beat", 64'(q.size()), 64'd0);
    check("orphan_err", 64'(err), 64'd3);

    // Reset in the middle of a packet discards it and clears sticky errors
    send(1, 0, 2'd0, 32'h00000077, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_iready", 64'(bus.iready), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4);
    check("midrst_no_beat", 64'(q.size()), 64'd0);
    check("midrst_err", 64'(err), 64'd0);

    // 4100 full words: length saturates and the packet is forced bad
    quiet = 1'b1;
    for (int i = 0; i < 4100; i++) send(i == 0, i == 4099, 2'd0, 32'(i), 0);
    wait_beats(2050, 100);
    quiet = 1'b0;
    check("long_beats", 64'(q.size()), 64'd2050);
    eop_beats = 0;
    last = '{default: '0};
    while (q.size() > 0) begin
      last = q.pop_front();
      if (last.eop) eop_beats++;
    end
    $display("long packet last beat data=%h len=%0d bad=%0b", last.data, last.len, last.bad);
    check("long_eop_beats", 64'(eop_beats), 64'd1);
    check("long_last_data", last.data, 64'h00001002_00001003);
    check("long_len", 64'(last.len), 64'd16383);
    check("long_bad", 64'(last.bad), 64'd1);
    check("long_err", 64'(err), 64'd4);
`ifdef PACKET_WIDTH_UPSIZER_STATS_EN
    exp_cnt = 32'd1;
`else
    exp_cnt = 32'd0;
`endif
    check("long_pkt_cnt", 64'(pkt_cnt), 64'(exp_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
